// File: rtl/cache_pkg.sv
// Shared definitions for the set-associative write-through cache: FSM states,
// address-split width helpers and the statistics counter width.
package cache_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOOKUP = 3'd1,
    ST_FILL   = 3'd2,
    ST_WTHRU  = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  localparam int CNT_W = 16;

  function automatic int off_w(input int line_bytes);
    return $clog2(line_bytes);
  endfunction

  function automatic int idx_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_w(input int addr_w, input int line_bytes, input int sets);
    return addr_w - $clog2(line_bytes) - $clog2(sets);
  endfunction

  // Statistics counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/cache_way.sv
// One way of the cache: valid bits (reset), tag and data arrays (not reset)
// and the tag compare for the currently addressed set.
module cache_way
  import cache_pkg::*;
#(
  parameter int LINE_BYTES = 4,
  parameter int SETS       = 4,
  parameter int TAG_W      = 4,
  parameter int IDX_AW     = 2,
  parameter int OFF_W      = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush_i,
  input  logic [IDX_AW-1:0]       idx_i,
  input  logic [TAG_W-1:0]        tag_i,
  input  logic                    fill_en_i,
  input  logic [8*LINE_BYTES-1:0] fill_line_i,
  input  logic                    wr_en_i,
  input  logic [OFF_W-1:0]        wr_off_i,
  input  logic [7:0]              wr_byte_i,
  output logic                    hit_o,
  output logic                    valid_o,
  output logic [8*LINE_BYTES-1:0] line_o
);

  logic [SETS-1:0]         valid_q;
  logic [TAG_W-1:0]        tag_q  [SETS];
  logic [8*LINE_BYTES-1:0] data_q [SETS];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
    end else if (flush_i) begin
      valid_q <= '0;
    end else if (fill_en_i) begin
      valid_q[idx_i] <= 1'b1;
    end
  end

  // Contents are only meaningful behind a valid bit, so no reset here.
  always_ff @(posedge clk) begin
    if (fill_en_i) begin
      tag_q[idx_i]  <= tag_i;
      data_q[idx_i] <= fill_line_i;
    end else if (wr_en_i) begin
      data_q[idx_i][{wr_off_i, 3'b000} +: 8] <= wr_byte_i;
    end
  end

  assign valid_o = valid_q[idx_i];
  assign hit_o   = valid_o && (tag_q[idx_i] == tag_i);
  assign line_o  = data_q[idx_i];

endmodule

// File: rtl/cache_assoc.sv
// Read-allocate, write-through, no-write-allocate cache with 1 or 2 ways,
// single-bit LRU per set and saturating hit/miss statistics.
module cache_assoc
  import cache_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int LINE_BYTES = 4,
  parameter int SETS       = 4,
  parameter int WAYS       = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    PRead_request,
  input  logic                    PWrite_request,
  input  logic [ADDR_W-1:0]       PAddress,
  input  logic [7:0]              PWrite_data,
  output logic [7:0]              PRead_data,
  output logic                    PRead_ready,
  output logic                    PWrite_done,
  output logic                    MRead_request,
  output logic                    MWrite_request,
  output logic [ADDR_W-1:0]       MAddress,
  output logic [7:0]              MWrite_data,
  input  logic [8*LINE_BYTES-1:0] MRead_data,
  input  logic                    MRead_ready,
  input  logic                    MWrite_done,
  output logic [CNT_W-1:0]        hit_count,
  output logic [CNT_W-1:0]        miss_count,
  output state_e                  dbg_state_o
);

  localparam int OFF_W  = off_w(LINE_BYTES);
  localparam int IDX_W  = idx_w(SETS);
  localparam int IDX_AW = (IDX_W > 0) ? IDX_W : 1;
  localparam int TAG_W  = tag_w(ADDR_W, LINE_BYTES, SETS);

  // Handshakes: processor requests are levels held until the matching
  // ready/done; memory requests are held until MRead_ready/MWrite_done.
  state_e              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [7:0]          wdata_q;
  logic                is_wr_q;
  logic [7:0]          pread_data_q;
  logic                pread_ready_q;
  logic                pwrite_done_q;
  logic                mread_req_q;
  logic                mwrite_req_q;
  logic [ADDR_W-1:0]   maddr_q;
  logic [7:0]          mwdata_q;
  logic [CNT_W-1:0]    hit_cnt_q;
  logic [CNT_W-1:0]    miss_cnt_q;
  logic [SETS-1:0]     lru_q;

  logic [IDX_AW-1:0]       cur_idx;
  logic [TAG_W-1:0]        cur_tag;
  logic [OFF_W-1:0]        cur_off;
  logic [ADDR_W-1:0]       line_addr;
  logic [WAYS-1:0]         hit_vec;
  logic [WAYS-1:0]         valid_vec;
  logic [8*LINE_BYTES-1:0] line_arr [WAYS];
  logic [8*LINE_BYTES-1:0] hit_line;
  logic                    any_hit;
  logic                    hit_way;
  logic                    victim;
  logic                    flush_en;
  logic                    fill_en;
  logic                    wr_hit_en;

  function automatic logic [7:0] sel_byte(input logic [8*LINE_BYTES-1:0] line,
                                          input logic [OFF_W-1:0] off);
    return line[{off, 3'b000} +: 8];
  endfunction

  assign cur_off   = addr_q[OFF_W-1:0];
  assign cur_idx   = addr_q[OFF_W +: IDX_AW] & IDX_AW'(SETS - 1);
  assign cur_tag   = addr_q[ADDR_W-1 -: TAG_W];
  assign line_addr = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

  assign flush_en  = (state_q == ST_IDLE) && flush;
  assign fill_en   = (state_q == ST_FILL) && MRead_ready;
  assign wr_hit_en = (state_q == ST_LOOKUP) && is_wr_q && any_hit;
  assign any_hit   = |hit_vec;

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    cache_way #(
      .LINE_BYTES(LINE_BYTES),
      .SETS      (SETS),
      .TAG_W     (TAG_W),
      .IDX_AW    (IDX_AW),
      .OFF_W     (OFF_W)
    ) u_way (
      .clk        (clk),
      .rst        (rst),
      .flush_i    (flush_en),
      .idx_i      (cur_idx),
      .tag_i      (cur_tag),
      .fill_en_i  (fill_en && (victim == 1'(w))),
      .fill_line_i(MRead_data),
      .wr_en_i    (wr_hit_en && hit_vec[w]),
      .wr_off_i   (cur_off),
      .wr_byte_i  (wdata_q),
      .hit_o      (hit_vec[w]),
      .valid_o    (valid_vec[w]),
      .line_o     (line_arr[w])
    );
  end

  // Victim: first invalid way (way 0 preferred), else the LRU way of the set.
  if (WAYS == 2) begin : g_two
    assign hit_way  = hit_vec[1];
    assign hit_line = hit_vec[1] ? line_arr[1] : line_arr[0];
    assign victim   = !valid_vec[0] ? 1'b0 :
                      !valid_vec[1] ? 1'b1 : lru_q[cur_idx];
  end else begin : g_one
    assign hit_way  = 1'b0;
    assign hit_line = line_arr[0];
    assign victim   = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      addr_q        <= '0;
      wdata_q       <= '0;
      is_wr_q       <= 1'b0;
      pread_data_q  <= '0;
      pread_ready_q <= 1'b0;
      pwrite_done_q <= 1'b0;
      mread_req_q   <= 1'b0;
      mwrite_req_q  <= 1'b0;
      maddr_q       <= '0;
      mwdata_q      <= '0;
      hit_cnt_q     <= '0;
      miss_cnt_q    <= '0;
      lru_q         <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (flush) lru_q <= '0;
          if (PWrite_request) begin
            is_wr_q <= 1'b1;
            addr_q  <= PAddress;
            wdata_q <= PWrite_data;
            state_q <= ST_LOOKUP;
          end else if (PRead_request) begin
            is_wr_q <= 1'b0;
            addr_q  <= PAddress;
            wdata_q <= PWrite_data;
            state_q <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          if (any_hit) begin
            hit_cnt_q <= sat_inc(hit_cnt_q);
            if (WAYS == 2) lru_q[cur_idx] <= ~hit_way;
          end else begin
            miss_cnt_q <= sat_inc(miss_cnt_q);
          end
          if (is_wr_q) begin
            mwrite_req_q <= 1'b1;
            maddr_q      <= addr_q;
            mwdata_q     <= wdata_q;
            state_q      <= ST_WTHRU;
          end else if (any_hit) begin
            pread_data_q <= sel_byte(hit_line, cur_off);
            state_q      <= ST_DONE;
          end else begin
            mread_req_q <= 1'b1;
            maddr_q     <= line_addr;
            state_q     <= ST_FILL;
          end
        end
        ST_FILL: begin
          if (MRead_ready) begin
            mread_req_q  <= 1'b0;
            pread_data_q <= sel_byte(MRead_data, cur_off);
            if (WAYS == 2) lru_q[cur_idx] <= ~victim;
            state_q      <= ST_DONE;
          end
        end
        ST_WTHRU: begin
          if (MWrite_done) begin
            mwrite_req_q <= 1'b0;
            state_q      <= ST_DONE;
          end
        end
        ST_DONE: begin
          // First DONE cycle raises the completion flag; it then holds
          // until the processor drops its request.
          if (is_wr_q) begin
            if (!pwrite_done_q) begin
              pwrite_done_q <= 1'b1;
            end else if (!PWrite_request) begin
              pwrite_done_q <= 1'b0;
              state_q       <= ST_IDLE;
            end
          end else begin
            if (!pread_ready_q) begin
              pread_ready_q <= 1'b1;
            end else if (!PRead_request) begin
              pread_ready_q <= 1'b0;
              state_q       <= ST_IDLE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign PRead_data     = pread_data_q;
  assign PRead_ready    = pread_ready_q;
  assign PWrite_done    = pwrite_done_q;
  assign MRead_request  = mread_req_q;
  assign MWrite_request = mwrite_req_q;
  assign MAddress       = maddr_q;
  assign MWrite_data    = mwdata_q;
  assign hit_count      = hit_cnt_q;
  assign miss_count     = miss_cnt_q;
  assign dbg_state_o    = state_q;

endmodule
